bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter BIN_WIDTH, default 32: width of the binary input, legal range 1..64.
REQ-002 The block SHALL have parameter NUM_DIGITS, default 10: number of BCD output digits, legal range 1..20.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port bin_in, input, BIN_WIDTH bits: binary value to convert.
REQ-006 The block SHALL have port in_valid, input, 1 bit: bin_in is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a value.
REQ-008 The block SHALL have port bcd_out, output, [NUM_DIGITS-1:0][3:0]: packed BCD result, digit 0 least significant.
REQ-009 The block SHALL have port overflow, output, 1 bit: the value is at least 10^NUM_DIGITS, so bcd_out holds the value mod 10^NUM_DIGITS.
REQ-010 The block SHALL have port out_valid, output, 1 bit: bcd_out and overflow are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, CONV and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE.
REQ-014 An accept SHALL occur on an edge where in_valid and in_ready are both 1; it latches bin_in and moves the FSM IDLE->CONV.
REQ-015 In CONV the block SHALL do one double-dabble step per cycle, in this order: add 3 to every digit >= 5, then shift the binary register MSB into digit 0.
REQ-016 CONV SHALL last exactly BIN_WIDTH cycles, and out_valid SHALL rise on the BIN_WIDTH-th edge after the accepting edge, with the FSM in DONE.
REQ-017 A 1 bit shifted out of the top digit during any step SHALL set overflow sticky for the current conversion; the lower digits SHALL remain exact (value mod 10^NUM_DIGITS).
REQ-018 In DONE, bcd_out and overflow SHALL hold stable while out_ready=0.
REQ-019 On an edge in DONE with out_ready=1, the FSM SHALL return to IDLE and out_valid SHALL fall; in_ready SHALL rise in the same edge.
REQ-020 No accept SHALL occur on the edge that leaves DONE (minimum spacing between results is BIN_WIDTH+2 cycles).
REQ-021 bcd_out and overflow SHALL keep their last result in IDLE and SHALL be cleared at the next accept.
REQ-022 in_valid and bin_in SHALL be ignored outside IDLE.
REQ-023 out_ready SHALL be ignored outside DONE.

Reset
REQ-024 When rst=0 at an edge the block SHALL force: FSM=IDLE, bcd_out=0, overflow=0, out_valid=0, in_ready=1, shift counter=0.
REQ-025 Reset SHALL take priority over every other event, including an accept or a consume on the same edge.
REQ-026 Reset during CONV or DONE SHALL abort the conversion with no result delivered.
REQ-027 in_ready SHALL be 1 on the first edge after rst returns to 1.

Configuration
REQ-028 Macro BIN2BCD_SIGNED_EN SHALL select signed or unsigned operation.
REQ-029 With BIN2BCD_SIGNED_EN defined, bin_in SHALL be read as two's complement.
REQ-030 With BIN2BCD_SIGNED_EN defined, the magnitude (BIN_WIDTH-bit unsigned, so -2^(BIN_WIDTH-1) is exact) SHALL be converted.
REQ-031 With BIN2BCD_SIGNED_EN defined, an extra output port sign_out (1 bit) SHALL be 1 for a negative input; it is registered with the other results, reset to 0 and cleared at accept.
REQ-032 Without BIN2BCD_SIGNED_EN, bin_in SHALL be unsigned and port sign_out SHALL not exist.

Verification
REQ-033 BIN_WIDTH=32, NUM_DIGITS=3, accept 0x0B -> out_valid exactly 32 edges later, bcd_out=0x011, overflow=0.
REQ-034 BIN_WIDTH=32, NUM_DIGITS=3: input 999 -> 0x999, overflow=0; input 1000 -> 0x000, overflow=1; input 1234 -> 0x234, overflow=1.
REQ-035 BIN_WIDTH=32, NUM_DIGITS=10, input 0xFFFFFFFF -> bcd_out=0x4294967295, overflow=0.
REQ-036 Hold out_ready=0 for 20 cycles in DONE with in_valid=1 -> result stable, in_ready=0, no accept; then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 next edge.
REQ-037 rst=0 for one edge at cycle 10 of CONV -> all outputs at reset values, out_valid never rises; the next accept of 42 -> 0x042.
REQ-038 BIN2BCD_SIGNED_EN, BIN_WIDTH=8, NUM_DIGITS=3: input 0xFB -> 0x005, sign_out=1; input 0x80 -> 0x128, sign_out=1; input 0x7F -> 0x127, sign_out=0.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// Define BIN2BCD_SIGNED_EN to read bin_in as two's complement and add sign_out.
module bin2bcd_seq #(
   parameter int BIN_WIDTH  = 32,
   parameter int NUM_DIGITS = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [BIN_WIDTH-1:0]         bin_in,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [NUM_DIGITS-1:0][3:0]   bcd_out,
   output logic                         overflow,
   output logic                         out_valid,
`ifdef BIN2BCD_SIGNED_EN
   output logic                         sign_out,
`endif
   input  logic                         out_ready
);
   localparam int CW = $clog2(BIN_WIDTH + 1);
   localparam int DW = 4 * NUM_DIGITS;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t                     state, state_nx;
   logic [BIN_WIDTH-1:0]       bin_q, mag;
   logic [CW-1:0]              cnt;
   logic [NUM_DIGITS-1:0][3:0] adj;
   logic [DW-1:0]              adj_flat;
   logic                       accept, last_step;

   assign accept    = in_valid && in_ready;
   assign last_step = (cnt == CW'(BIN_WIDTH - 1));

`ifdef BIN2BCD_SIGNED_EN
   // Magnitude fits in BIN_WIDTH unsigned bits, so the most negative value is exact.
   assign mag = bin_in[BIN_WIDTH-1] ? (~bin_in + BIN_WIDTH'(1)) : bin_in;
`else
   assign mag = bin_in;
`endif

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = CONV;
         end
         CONV: if (last_step) state_nx = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      adj = bcd_out;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (bcd_out[i] >= 4'd5) adj[i] = bcd_out[i] + 4'd3;
   end
   assign adj_flat = adj;

   // The bit leaving the top digit is a lost multiple of 10^NUM_DIGITS.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bin_q    <= '0;
         cnt      <= '0;
         bcd_out  <= '0;
         overflow <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
         sign_out <= 1'b0;
`endif
      end else if (accept) begin
         bin_q    <= mag;
         cnt      <= '0;
         bcd_out  <= '0;
         overflow <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
         sign_out <= bin_in[BIN_WIDTH-1];
`endif
      end else if (state == CONV) begin
         bin_q    <= bin_q << 1;
         bcd_out  <= {adj_flat[DW-2:0], bin_q[BIN_WIDTH-1]};
         overflow <= overflow | adj_flat[DW-1];
         cnt      <= last_step ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: three instances (32b/3 digits, 32b/10 digits, 8b/3 digits).
module tb_bin2bcd_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] bin_a, bin_b;
   logic [7:0]  bin_c;
   logic [2:0]  iv, ordy, ir, ov, of;
   logic [11:0] bcd_a, bcd_c;
   logic [39:0] bcd_b;
`ifdef BIN2BCD_SIGNED_EN
   logic [2:0]  sg;
`endif
   int total = 0;
   int bad   = 0;

   bin2bcd_seq #(.BIN_WIDTH(32), .NUM_DIGITS(3)) dut_a (
      .clk(clk), .rst(rst), .bin_in(bin_a), .in_valid(iv[0]), .in_ready(ir[0]),
      .bcd_out(bcd_a), .overflow(of[0]), .out_valid(ov[0]),
`ifdef BIN2BCD_SIGNED_EN
      .sign_out(sg[0]),
`endif
      .out_ready(ordy[0]));

   bin2bcd_seq #(.BIN_WIDTH(32), .NUM_DIGITS(10)) dut_b (
      .clk(clk), .rst(rst), .bin_in(bin_b), .in_valid(iv[1]), .in_ready(ir[1]),
      .bcd_out(bcd_b), .overflow(of[1]), .out_valid(ov[1]),
`ifdef BIN2BCD_SIGNED_EN
      .sign_out(sg[1]),
`endif
      .out_ready(ordy[1]));

   bin2bcd_seq #(.BIN_WIDTH(8), .NUM_DIGITS(3)) dut_c (
      .clk(clk), .rst(rst), .bin_in(bin_c), .in_valid(iv[2]), .in_ready(ir[2]),
      .bcd_out(bcd_c), .overflow(of[2]), .out_valid(ov[2]),
`ifdef BIN2BCD_SIGNED_EN
      .sign_out(sg[2]),
`endif
      .out_ready(ordy[2]));

   // Accept one value on instance sel, wait for the result, then consume it.
   task automatic run(input int sel, input logic [31:0] v,
                      output logic [39:0] bcd, output logic ovf, output int lat);
      int w;
      @(negedge clk);
      w = 0;
      while (!ir[sel] && w < 100) begin @(negedge clk); w++; end
      bin_a = v; bin_b = v; bin_c = v[7:0];
      iv[sel] = 1'b1;
      @(posedge clk); #1 iv[sel] = 1'b0;
      lat = 0;
      while (!ov[sel] && lat < 200) begin @(posedge clk); lat++; #1; end
      bcd = (sel == 0) ? {28'd0, bcd_a} : (sel == 1) ? bcd_b : {28'd0, bcd_c};
      ovf = of[sel];
      @(negedge clk); ordy[sel] = 1'b1;
      @(posedge clk); #1 ordy[sel] = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; iv = 3'b111; ordy = 3'b111;
      bin_a = 32'd5; bin_b = 32'd5; bin_c = 8'd5;
      repeat (2) @(posedge clk);
      #1;
      total++; if (ir !== 3'b111) begin bad++; $display("FAIL reset_in_ready got=%b want=111", ir); end
      total++; if (ov !== 3'b000 || of !== 3'b000) begin bad++; $display("FAIL reset_flags ov=%b of=%b want 000", ov, of); end
      total++; if (bcd_a !== 12'h0 || bcd_b !== 40'h0 || bcd_c !== 12'h0) begin
         bad++; $display("FAIL reset_bcd a=%h b=%h c=%h want 0", bcd_a, bcd_b, bcd_c); end
      @(negedge clk); iv = 3'b000; ordy = 3'b000; rst = 1'b1;
      @(posedge clk); #1;
      total++; if (ir !== 3'b111) begin bad++; $display("FAIL reset_release_ready got=%b want=111", ir); end
   endtask

   task automatic test_basic;
      logic [39:0] b; logic o; int l;
      run(0, 32'h0B, b, o, l);
      total++; if (l !== 32) begin bad++; $display("FAIL basic_latency got=%0d want=32", l); end
      total++; if (b[11:0] !== 12'h011 || o !== 1'b0) begin bad++; $display("FAIL basic_value got=%h ovf=%b want=011 ovf=0", b[11:0], o); end
      total++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bcd_a !== 12'h011) begin
         bad++; $display("FAIL basic_after_consume ir=%b ov=%b bcd=%h want 1 0 011", ir[0], ov[0], bcd_a); end
   endtask

   task automatic test_overflow;
      logic [31:0] vin  [4] = '{32'd999, 32'd1000, 32'd1234, 32'd5};
      logic [11:0] vexp [4] = '{12'h999, 12'h000, 12'h234, 12'h005};
      logic        oexp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [39:0] b; logic o; int l;
      for (int i = 0; i < 4; i++) begin
         run(0, vin[i], b, o, l);
         total++; if (b[11:0] !== vexp[i] || o !== oexp[i] || l !== 32) begin
            bad++; $display("FAIL overflow_%0d got=%h ovf=%b lat=%0d want=%h ovf=%b lat=32", vin[i], b[11:0], o, l, vexp[i], oexp[i]); end
      end
   endtask

   task automatic test_wide;
      logic [31:0] vin  [4] = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h3B9A_CA00};
`ifdef BIN2BCD_SIGNED_EN
      logic [39:0] vexp [4] = '{40'h1, 40'h0, 40'h2147483648, 40'h1000000000};
`else
      logic [39:0] vexp [4] = '{40'h4294967295, 40'h0, 40'h2147483648, 40'h1000000000};
`endif
      logic [39:0] b; logic o; int l;
      for (int i = 0; i < 4; i++) begin
         run(1, vin[i], b, o, l);
         total++; if (b !== vexp[i] || o !== 1'b0 || l !== 32) begin
            bad++; $display("FAIL wide_%h got=%h ovf=%b lat=%0d want=%h ovf=0 lat=32", vin[i], b, o, l, vexp[i]); end
      end
   endtask

   task automatic test_small;
      logic [31:0] vin  [4] = '{32'hFB, 32'h80, 32'h7F, 32'h00};
`ifdef BIN2BCD_SIGNED_EN
      logic [11:0] vexp [4] = '{12'h005, 12'h128, 12'h127, 12'h000};
      logic        sexp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
      logic [11:0] vexp [4] = '{12'h251, 12'h128, 12'h127, 12'h000};
`endif
      logic [39:0] b; logic o; int l;
      for (int i = 0; i < 4; i++) begin
         run(2, vin[i], b, o, l);
         total++; if (b[11:0] !== vexp[i] || o !== 1'b0 || l !== 8) begin
            bad++; $display("FAIL small_%h got=%h ovf=%b lat=%0d want=%h ovf=0 lat=8", vin[i][7:0], b[11:0], o, l, vexp[i]); end
`ifdef BIN2BCD_SIGNED_EN
         total++; if (sg[2] !== sexp[i]) begin bad++; $display("FAIL sign_%h got=%b want=%b", vin[i][7:0], sg[2], sexp[i]); end
`endif
      end
   endtask

   task automatic test_hold;
      int  l;
      logic ok;
      @(negedge clk); bin_a = 32'd7; iv[0] = 1'b1;
      @(posedge clk); #1 iv[0] = 1'b0;
      l = 0;
      while (!ov[0] && l < 200) begin @(posedge clk); l++; #1; end
      total++; if (l !== 32) begin bad++; $display("FAIL hold_latency got=%0d want=32", l); end
      bin_a = 32'd555; iv[0] = 1'b1;
      ok = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (bcd_a !== 12'h007 || ir[0] !== 1'b0 || ov[0] !== 1'b1 || of[0] !== 1'b0) ok = 1'b0;
      end
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL hold_stable got bcd=%h ir=%b ov=%b want 007 0 1", bcd_a, ir[0], ov[0]); end
      ordy[0] = 1'b1;
      @(posedge clk); #1 ordy[0] = 1'b0;
      total++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin bad++; $display("FAIL hold_release ov=%b ir=%b want 0 1", ov[0], ir[0]); end
      total++; if (bcd_a !== 12'h007) begin bad++; $display("FAIL hold_keep got=%h want=007", bcd_a); end
      iv[0] = 1'b0;
   endtask

   task automatic test_reset_conv;
      logic [39:0] b; logic o; int l;
      logic seen;
      @(negedge clk); bin_a = 32'd999; iv[0] = 1'b1;
      @(posedge clk); #1 iv[0] = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b0; ordy[0] = 1'b1;
      @(posedge clk); #1 rst = 1'b1; ordy[0] = 1'b0;
      total++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || of[0] !== 1'b0 || bcd_a !== 12'h0) begin
         bad++; $display("FAIL abort_reset ir=%b ov=%b of=%b bcd=%h want 1 0 0 000", ir[0], ov[0], of[0], bcd_a); end
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (ov[0] !== 1'b0) seen = 1'b1; end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_result out_valid rose=%b want 0", seen); end
      run(0, 32'd42, b, o, l);
      total++; if (b[11:0] !== 12'h042 || o !== 1'b0 || l !== 32) begin
         bad++; $display("FAIL abort_next got=%h ovf=%b lat=%0d want=042 ovf=0 lat=32", b[11:0], o, l); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_overflow;
      test_wide;
      test_small;
      test_hold;
      test_reset_conv;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
